// File: rtl/sha_mem_responder.sv
// Word-addressed memory responder for the SHA-256 engine: host preload, engine read/write, digest capture.
// Optional access statistics are built when SHA_MEM_RESP_STATS_EN is defined; otherwise rd_count/wr_count read 0.
module sha_mem_responder #(
  parameter int unsigned DEPTH    = 256,
  parameter logic [31:0] OOB_DATA = 32'hDEADBEEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          mem_we,
  input  logic [15:0]   mem_addr,
  input  logic [31:0]   mem_write_data,
  output logic [31:0]   mem_read_data,
  input  logic          ld_valid,
  input  logic [15:0]   ld_addr,
  input  logic [31:0]   ld_data,
  input  logic [15:0]   cap_base,
  input  logic          cap_clear,
  output logic          cap_valid,
  output logic [255:0]  hash_out,
  output logic          err_oob,
  output logic          err_coll,
  output logic [15:0]   rd_count,
  output logic [15:0]   wr_count
);

  localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [16:0] DEPTH_W = 17'(DEPTH);

  typedef enum logic [1:0] {
    CAP_IDLE,
    CAP_FILL,
    CAP_DONE
  } cap_state_e;

  logic [31:0]       mem [DEPTH];

  cap_state_e        state_q;
  logic [7:0]        mask_q;
  logic [15:0]       base_q;
  logic [7:0][31:0]  hash_q;
  logic              valid_q;
  logic [31:0]       rd_data_q;
  logic              oob_q;
  logic              coll_q;

  logic              ld_in_range;
  logic              mem_in_range;
  logic              eng_wr;
  logic              eng_rd;
  logic              ram_we;
  logic [AW-1:0]     ram_idx;
  logic [31:0]       ram_wdata;
  logic              oob_hit;
  logic [15:0]       win_base;
  logic [15:0]       win_off;
  logic              win_hit;
  logic [2:0]        slot;

  always_comb begin
    ld_in_range  = {1'b0, ld_addr} < DEPTH_W;
    mem_in_range = {1'b0, mem_addr} < DEPTH_W;
    eng_wr       = mem_we && !ld_valid;
    eng_rd       = !mem_we && !ld_valid;
    ram_we       = (ld_valid && ld_in_range) || (eng_wr && mem_in_range);
    ram_idx      = ld_valid ? ld_addr[AW-1:0] : mem_addr[AW-1:0];
    ram_wdata    = ld_valid ? ld_data : mem_write_data;
    oob_hit      = ld_valid ? !ld_in_range : !mem_in_range;
    // While idle the window follows cap_base live; once a digest word lands it is frozen in base_q.
    // Offset is only trusted when addr >= base, so the window can never wrap past 16'hFFFF.
    win_base     = (state_q == CAP_IDLE) ? cap_base : base_q;
    win_off      = mem_addr - win_base;
    win_hit      = eng_wr && (mem_addr >= win_base) && (win_off < 16'd8);
    slot         = win_off[2:0];
  end

  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem[ram_idx] <= ram_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_q <= '0;
      oob_q     <= 1'b0;
      coll_q    <= 1'b0;
    end else begin
      if (eng_rd) begin
        rd_data_q <= mem_in_range ? mem[mem_addr[AW-1:0]] : OOB_DATA;
      end
      if (oob_hit) begin
        oob_q <= 1'b1;
      end
      if (ld_valid && mem_we) begin
        coll_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || cap_clear) begin
      state_q <= CAP_IDLE;
      mask_q  <= '0;
      hash_q  <= '0;
      valid_q <= 1'b0;
      base_q  <= cap_base;
    end else begin
      case (state_q)
        CAP_IDLE: begin
          base_q <= cap_base;
          if (win_hit) begin
            hash_q[3'd7 - slot] <= mem_write_data;
            mask_q[slot]        <= 1'b1;
            state_q             <= CAP_FILL;
          end
        end
        CAP_FILL: begin
          if (win_hit) begin
            hash_q[3'd7 - slot] <= mem_write_data;
            mask_q[slot]        <= 1'b1;
          end
          if (mask_q == 8'hFF) begin
            state_q <= CAP_DONE;
            valid_q <= 1'b1;
          end
        end
        CAP_DONE: begin
          valid_q <= 1'b1;
        end
        default: begin
          state_q <= CAP_IDLE;
        end
      endcase
    end
  end

`ifdef SHA_MEM_RESP_STATS_EN
  logic [15:0] rd_cnt_q;
  logic [15:0] wr_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      if (eng_rd && (rd_cnt_q != '1)) begin
        rd_cnt_q <= rd_cnt_q + 16'd1;
      end
      if (eng_wr && mem_in_range && (wr_cnt_q != '1)) begin
        wr_cnt_q <= wr_cnt_q + 16'd1;
      end
    end
  end

  assign rd_count = rd_cnt_q;
  assign wr_count = wr_cnt_q;
`else
  assign rd_count = '0;
  assign wr_count = '0;
`endif

  assign mem_read_data = rd_data_q;
  assign cap_valid     = valid_q;
  assign hash_out      = hash_q;
  assign err_oob       = oob_q;
  assign err_coll      = coll_q;

endmodule

// File: tb/tb_sha_mem_responder.sv
// Self-checking bench for sha_mem_responder: vector table, capture sequences and randomized traffic vs. a memory model.
module tb_sha_mem_responder;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          mem_we = 1'b0;
  logic [15:0]   mem_addr = '0;
  logic [31:0]   mem_write_data = '0;
  logic [31:0]   mem_read_data;
  logic          ld_valid = 1'b0;
  logic [15:0]   ld_addr = '0;
  logic [31:0]   ld_data = '0;
  logic [15:0]   cap_base = 16'h0080;
  logic          cap_clear = 1'b0;
  logic          cap_valid;
  logic [255:0]  hash_out;
  logic          err_oob;
  logic          err_coll;
  logic [15:0]   rd_count;
  logic [15:0]   wr_count;

`ifdef SHA_MEM_RESP_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  localparam logic [31:0] OOB = 32'hDEADBEEF;

  sha_mem_responder #(.DEPTH(256), .OOB_DATA(OOB)) dut (
    .clk(clk), .reset(reset), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
    .cap_base(cap_base), .cap_clear(cap_clear), .cap_valid(cap_valid),
    .hash_out(hash_out), .err_oob(err_oob), .err_coll(err_coll),
    .rd_count(rd_count), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  int unsigned total = 0;
  int unsigned bad   = 0;

  // Reference model: plain word array with a "has been written" flag per word.
  logic [31:0] m  [256];
  bit          kn [256];
  logic [31:0] e_rd;
  bit          e_rd_kn = 1'b0;
  bit          e_oob, e_coll;
  int unsigned e_rdc, e_wrc;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    e_rd = '0; e_rd_kn = 1'b1; e_oob = 1'b0; e_coll = 1'b0; e_rdc = 0; e_wrc = 0;
  endtask

  task automatic check_model();
    if (e_rd_kn) chk("rd_data", {224'b0, mem_read_data}, {224'b0, e_rd});
    chk("err_oob", {255'b0, err_oob}, {255'b0, e_oob});
    chk("err_coll", {255'b0, err_coll}, {255'b0, e_coll});
    chk("rd_count", {240'b0, rd_count}, STATS ? 256'(e_rdc) : 256'b0);
    chk("wr_count", {240'b0, wr_count}, STATS ? 256'(e_wrc) : 256'b0);
  endtask

  // One clock of stimulus; the model advances from the same inputs and the outputs are checked after the edge.
  task automatic cyc(input logic lv, input logic [15:0] la, input logic [31:0] ldd,
                     input logic we, input logic [15:0] a, input logic [31:0] wd, input logic clr);
    ld_valid = lv; ld_addr = la; ld_data = ldd;
    mem_we = we; mem_addr = a; mem_write_data = wd; cap_clear = clr;
    @(posedge clk);
    #1;
    if (lv) begin
      if (la < 16'd256) begin m[la[7:0]] = ldd; kn[la[7:0]] = 1'b1; end
      else e_oob = 1'b1;
      if (we) e_coll = 1'b1;
    end else if (we) begin
      if (a < 16'd256) begin
        m[a[7:0]] = wd; kn[a[7:0]] = 1'b1;
        if (e_wrc < 65535) e_wrc++;
      end else e_oob = 1'b1;
    end else begin
      if (a < 16'd256) begin e_rd = m[a[7:0]]; e_rd_kn = kn[a[7:0]]; end
      else begin e_rd = OOB; e_rd_kn = 1'b1; e_oob = 1'b1; end
      if (e_rdc < 65535) e_rdc++;
    end
    check_model();
  endtask

  task automatic rd(input logic [15:0] a);
    cyc(1'b0, 16'h0, 32'h0, 1'b0, a, 32'h0, 1'b0);
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d);
    cyc(1'b0, 16'h0, 32'h0, 1'b1, a, d, 1'b0);
  endtask

  task automatic do_reset();
    ld_valid = 1'b0; mem_we = 1'b0; mem_addr = '0; cap_clear = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic chk_idle_outputs(input string nm);
    chk({nm, "_cap_valid"}, {255'b0, cap_valid}, 256'b0);
    chk({nm, "_hash_out"}, hash_out, 256'b0);
  endtask

  typedef struct {
    logic        lv;
    logic [15:0] la;
    logic [31:0] ldd;
    logic        we;
    logic [15:0] a;
    logic [31:0] wd;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [10];

  initial begin
    logic [255:0] exp_h;

    vecs[0] = '{1'b0, 16'h0, 32'h0,  1'b0, 16'd5,   32'h0,    32'h0000_0006};
    vecs[1] = '{1'b0, 16'h0, 32'h0,  1'b0, 16'd19,  32'h0,    32'h0000_0014};
    vecs[2] = '{1'b0, 16'h0, 32'h0,  1'b1, 16'd7,   32'hCAFE, 32'h0000_0014};
    vecs[3] = '{1'b0, 16'h0, 32'h0,  1'b0, 16'd7,   32'h0,    32'h0000_CAFE};
    vecs[4] = '{1'b0, 16'h0, 32'h0,  1'b0, 16'h100, 32'h0,    32'hDEAD_BEEF};
    vecs[5] = '{1'b0, 16'h0, 32'h0,  1'b1, 16'h100, 32'h1234, 32'hDEAD_BEEF};
    vecs[6] = '{1'b0, 16'h0, 32'h0,  1'b0, 16'd0,   32'h0,    32'h0000_0001};
    vecs[7] = '{1'b1, 16'd3, 32'h55, 1'b1, 16'd3,   32'h66,   32'h0000_0001};
    vecs[8] = '{1'b0, 16'h0, 32'h0,  1'b0, 16'd3,   32'h0,    32'h0000_0055};
    vecs[9] = '{1'b0, 16'h0, 32'h0,  1'b0, 16'h100, 32'h0,    32'hDEAD_BEEF};

    for (int i = 0; i < 256; i++) kn[i] = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    chk_idle_outputs("reset");
    check_model();

    // Preload and directed read/write/collision vectors.
    for (int i = 0; i < 20; i++) cyc(1'b1, 16'(i), 32'(i + 1), 1'b0, 16'h0, 32'h0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cyc(vecs[i].lv, vecs[i].la, vecs[i].ldd, vecs[i].we, vecs[i].a, vecs[i].wd, 1'b0);
      chk($sformatf("vec%0d_rd", i), {224'b0, mem_read_data}, {224'b0, vecs[i].exp_rd});
    end
    chk("vec_err_oob", {255'b0, err_oob}, 256'd1);
    chk("vec_err_coll", {255'b0, err_coll}, 256'd1);

    // Reverse-order digest fill.
    cap_base = 16'h0080;
    cyc(1'b0, 16'h0, 32'h0, 1'b0, 16'd0, 32'h0, 1'b1);
    for (int i = 7; i >= 0; i--) wr(16'h0080 + 16'(i), 32'hA0 + 32'(i));
    chk("revfill_valid_early", {255'b0, cap_valid}, 256'b0);
    chk("revfill_slot0", {224'b0, hash_out[255:224]}, 256'hA0);
    rd(16'd0);
    exp_h = '0;
    for (int i = 0; i < 8; i++) exp_h = {exp_h[223:0], 32'hA0 + 32'(i)};
    chk("revfill_valid", {255'b0, cap_valid}, 256'd1);
    chk("revfill_hash", hash_out, exp_h);
    chk("revfill_slot7", {224'b0, hash_out[31:0]}, 256'hA7);
    wr(16'h0080, 32'hFF);
    rd(16'h0080);
    chk("done_frozen", hash_out, exp_h);
    cyc(1'b0, 16'h0, 32'h0, 1'b0, 16'd0, 32'h0, 1'b1);
    chk_idle_outputs("clear1");

    // Slot 3 rewritten; completion waits for all eight distinct slots.
    wr(16'h0083, 32'h11);
    for (int i = 0; i < 7; i++) if (i != 3) wr(16'h0080 + 16'(i), 32'hB0 + 32'(i));
    wr(16'h0083, 32'h22);
    rd(16'd1);
    chk("rewrite_not_valid", {255'b0, cap_valid}, 256'b0);
    wr(16'h0087, 32'hB7);
    chk("rewrite_valid_early", {255'b0, cap_valid}, 256'b0);
    rd(16'd1);
    chk("rewrite_valid", {255'b0, cap_valid}, 256'd1);
    chk("rewrite_slot3", {224'b0, hash_out[159:128]}, 256'h22);
    exp_h = {32'hB0, 32'hB1, 32'hB2, 32'h22, 32'hB4, 32'hB5, 32'hB6, 32'hB7};
    chk("rewrite_hash", hash_out, exp_h);
    cyc(1'b0, 16'h0, 32'h0, 1'b1, 16'h0080, 32'h77, 1'b1);
    chk_idle_outputs("clear_wins");
    rd(16'h0080);
    chk("clear_wins_mem", {224'b0, mem_read_data}, 256'h77);
    chk("clear_wins_hash", hash_out, 256'b0);

    // Reset part-way through a capture.
    for (int i = 0; i < 4; i++) wr(16'h0080 + 16'(i), 32'hC0 + 32'(i));
    chk("partial_slot0", {224'b0, hash_out[255:224]}, 256'hC0);
    do_reset();
    chk_idle_outputs("midreset");
    check_model();
    for (int i = 0; i < 4; i++) begin
      rd(16'h0080 + 16'(i));
      chk($sformatf("midreset_mem%0d", i), {224'b0, mem_read_data}, 256'(32'hC0 + 32'(i)));
    end

    // Randomized traffic, window parked well outside the addresses used.
    cap_base = 16'hF000;
    cyc(1'b0, 16'h0, 32'h0, 1'b0, 16'd0, 32'h0, 1'b1);
    for (int i = 0; i < 256; i++) cyc(1'b1, 16'(i), $urandom, 1'b0, 16'h0, 32'h0, 1'b0);
    for (int i = 0; i < 600; i++) begin
      int unsigned r;
      r = $urandom_range(0, 99);
      if (r < 45)      rd(16'($urandom_range(0, 300)));
      else if (r < 75) wr(16'($urandom_range(0, 300)), $urandom);
      else if (r < 90) cyc(1'b1, 16'($urandom_range(0, 300)), $urandom, 1'b0, 16'h0, 32'h0, 1'b0);
      else             cyc(1'b1, 16'($urandom_range(0, 300)), $urandom, 1'b1,
                           16'($urandom_range(0, 300)), $urandom, 1'b0);
    end
    chk_idle_outputs("random");

    do_reset();
    chk_idle_outputs("final_reset");
    check_model();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
